// File: rtl/game_pkg.sv
// Shared geometry constants and camera FSM encoding, common to camera_frame_ctrl and pixel_gen.
// No logic; constants and types only.
package game_pkg;

  localparam int unsigned PHY_WIDTH    = 14;
  localparam int unsigned BLOCK_WIDTH  = 480;
  localparam int unsigned CHAR_WIDTH_Y = 32;
  localparam int unsigned CAM_WIDTH    = 5;
  localparam int unsigned MAX_CAMERA   = 31;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/iter_const_div.sv
// Repeated-subtract divider by a constant with quotient saturation; one subtract per enabled cycle.
// start loads the dividend; done is combinational and high once no further subtract is allowed.
module iter_const_div #(
  parameter int unsigned DW      = 15,
  parameter int unsigned DIVISOR = 480,
  parameter int unsigned QW      = 5,
  parameter int unsigned QMAX    = 31
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          step,
  input  logic [DW-1:0] dividend,
  output logic [QW-1:0] quot,
  output logic          done
);

  logic [DW-1:0] rem;

  // Saturated quotient also ends the division; the leftover remainder is simply dropped.
  assign done = !((rem >= DW'(DIVISOR)) && (quot < QW'(QMAX)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem  <= '0;
      quot <= '0;
    end else if (start) begin
      rem  <= dividend;
      quot <= '0;
    end else if (step && !done) begin
      rem  <= rem - DW'(DIVISOR);
      quot <= quot + QW'(1);
    end
  end

endmodule

// File: rtl/camera_frame_ctrl.sv
// Per-frame camera index and character snapshot for pixel_gen; commits q+2 edges after frame_start.
// frame_start while busy is dropped and latches the sticky overrun flag.
module camera_frame_ctrl #(
  parameter int unsigned PHY_WIDTH    = game_pkg::PHY_WIDTH,
  parameter int unsigned BLOCK_WIDTH  = game_pkg::BLOCK_WIDTH,
  parameter int unsigned CHAR_WIDTH_Y = game_pkg::CHAR_WIDTH_Y,
  parameter int unsigned CAM_WIDTH    = game_pkg::CAM_WIDTH,
  parameter int unsigned MAX_CAMERA   = game_pkg::MAX_CAMERA
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 frame_start,
  input  logic [PHY_WIDTH-1:0] char_abs_x,
  input  logic [PHY_WIDTH-1:0] char_abs_y,
  output logic [CAM_WIDTH-1:0] camera_y,
  output logic [PHY_WIDTH-1:0] char_snap_x,
  output logic [PHY_WIDTH-1:0] char_snap_y,
  output logic                 busy,
  output logic                 update_done,
  output logic                 overrun
);
  import game_pkg::*;

  localparam int unsigned DW = PHY_WIDTH + 1;

  state_t                 state, state_nxt;
  logic [DW-1:0]          dividend;
  logic                   div_start, div_step, div_done;
  logic [CAM_WIDTH-1:0]   div_quot;
  logic [PHY_WIDTH-1:0]   x_snap, y_snap;

  // One extra bit so the centre offset can never wrap.
  assign dividend = {1'b0, char_abs_y} + DW'(CHAR_WIDTH_Y / 2);
  assign busy     = (state != IDLE);

  iter_const_div #(
    .DW      (DW),
    .DIVISOR (BLOCK_WIDTH),
    .QW      (CAM_WIDTH),
    .QMAX    (MAX_CAMERA)
  ) u_div (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .start    (div_start),
    .step     (div_step),
    .dividend (dividend),
    .quot     (div_quot),
    .done     (div_done)
  );

  always_comb begin
    state_nxt = state;
    div_start = 1'b0;
    div_step  = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          state_nxt = DIVIDE;
          div_start = 1'b1;
        end
      end
      DIVIDE: begin
        div_step = 1'b1;
        if (div_done) state_nxt = COMMIT;
      end
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      x_snap      <= '0;
      y_snap      <= '0;
      camera_y    <= '0;
      char_snap_x <= '0;
      char_snap_y <= '0;
      update_done <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      update_done <= 1'b0;
      if (div_start) begin
        x_snap <= char_abs_x;
        y_snap <= char_abs_y;
      end
      // All visible outputs move together so pixel_gen never sees a mixed frame.
      if (state == COMMIT) begin
        camera_y    <= div_quot;
        char_snap_x <= x_snap;
        char_snap_y <= y_snap;
        update_done <= 1'b1;
      end
      if (frame_start && busy) overrun <= 1'b1;
    end
  end

endmodule
